// File: rtl/boa_mem_arbiter_if.sv
// Shared memory bus bundle: NPORTS requester lanes plus the single
// memory-side channel they are arbitrated onto.
interface boa_mem_arbiter_if #(
    parameter int NPORTS = 2
);
    logic [NPORTS-1:0]    req_re;
    logic [4*NPORTS-1:0]  req_we;
    logic [30*NPORTS-1:0] req_addr;
    logic [32*NPORTS-1:0] req_wdata;
    logic [32*NPORTS-1:0] req_rdata;
    logic [NPORTS-1:0]    req_ready;
    logic [NPORTS-1:0]    req_err;

    logic        mem_re;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        input  req_re, req_we, req_addr, req_wdata,
        input  mem_rdata, mem_ready,
        output req_rdata, req_ready, req_err,
        output mem_re, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_re, req_we, req_addr, req_wdata,
        output mem_rdata, mem_ready,
        input  req_rdata, req_ready, req_err,
        input  mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/boa_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory bus between
// NPORTS requesters; the granted request is registered for the transaction.
module boa_mem_arbiter #(
    parameter int NPORTS  = 2,
    parameter int TIMEOUT = 0,
    parameter int TW      = 8
) (
    input logic               clk,
    input logic               rst,
    boa_mem_arbiter_if.master bus
);
    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [IW-1:0] LAST_PORT = IW'(NPORTS - 1);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] rr_last_q, rr_last_d;
    logic [IW-1:0] grant_q, grant_d;
    logic          mem_re_q, mem_re_d;
    logic [3:0]    mem_we_q, mem_we_d;
    logic [29:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic [NPORTS-1:0] req_vld;
    logic [IW-1:0]     win;
    logic              win_vld;
    logic              done;
    logic              tmo;

    always_comb begin
        req_vld = '0;
        for (int i = 0; i < NPORTS; i++) begin
            req_vld[i] = bus.req_re[i] | (|bus.req_we[4*i +: 4]);
        end
    end

    // Scan from the farthest offset down so the nearest port after rr_last wins.
    always_comb begin
        int idx;
        idx     = 0;
        win     = rr_last_q;
        win_vld = 1'b0;
        for (int k = NPORTS; k >= 1; k--) begin
            idx = (int'(rr_last_q) + k) % NPORTS;
            if (req_vld[idx]) begin
                win     = IW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    assign done = (state_q == BUSY) && bus.mem_ready;
    assign tmo  = (TIMEOUT != 0) && (state_q == BUSY) &&
                  !bus.mem_ready && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        grant_d     = grant_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    mem_re_d    = bus.req_re[win];
                    mem_we_d    = bus.req_we[4*win +: 4];
                    mem_addr_d  = bus.req_addr[30*win +: 30];
                    mem_wdata_d = bus.req_wdata[32*win +: 32];
                    grant_d     = win;
                    rr_last_d   = win;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (done || tmo) begin
                    mem_re_d = 1'b0;
                    mem_we_d = '0;
                    state_d  = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_last_q   <= LAST_PORT;
            grant_q     <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            grant_q     <= grant_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // An aborted transaction must never complete, so reset masks responses.
    always_comb begin
        bus.req_ready = '0;
        bus.req_err   = '0;
        bus.req_rdata = '0;
        if (!rst && (done || tmo)) begin
            bus.req_ready[grant_q] = 1'b1;
            bus.req_err[grant_q]   = tmo;
            if (done) begin
                bus.req_rdata[32*grant_q +: 32] = bus.mem_rdata;
            end
        end
    end

    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Scoreboard bench: the driver predicts each grant and response from the
// round-robin and timeout rules; a negedge monitor pops on every req_ready.
module tb_boa_mem_arbiter;
    localparam int NP = 4;
    localparam int TO = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    boa_mem_arbiter_if #(.NPORTS(NP)) bus ();

    boa_mem_arbiter #(
        .NPORTS (NP),
        .TIMEOUT(TO),
        .TW     (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          port;
        int          cyc;
        bit          err;
        logic [31:0] rdata;
        logic        re;
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    bit          active[NP];
    logic        h_re[NP];
    logic [3:0]  h_we[NP];
    logic [29:0] h_addr[NP];
    logic [31:0] h_wdata[NP];
    int          rr_last = NP - 1;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitor: every req_ready pulse must match the oldest prediction.
    exp_t               m_e;
    logic [NP-1:0]      m_rdy;
    logic [NP-1:0]      m_err;
    logic [32*NP-1:0]   m_rd;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.req_ready != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 128'(bus.req_ready), 128'(0));
                end else begin
                    m_e   = exp_q.pop_front();
                    m_rdy = '0;
                    m_err = '0;
                    m_rd  = '0;
                    m_rdy[m_e.port] = 1'b1;
                    m_err[m_e.port] = m_e.err;
                    m_rd[32*m_e.port +: 32] = m_e.rdata;
                    chk("ready_vec", 128'(bus.req_ready), 128'(m_rdy));
                    chk("err_vec", 128'(bus.req_err), 128'(m_err));
                    chk("rdata_vec", 128'(bus.req_rdata), 128'(m_rd));
                    chk("ready_cycle", 128'(cyc), 128'(m_e.cyc));
                    chk("mem_re", 128'(bus.mem_re), 128'(m_e.re));
                    chk("mem_we", 128'(bus.mem_we), 128'(m_e.we));
                    chk("mem_addr", 128'(bus.mem_addr), 128'(m_e.addr));
                    chk("mem_wdata", 128'(bus.mem_wdata), 128'(m_e.wdata));
                end
            end else begin
                chk("quiet_err", 128'(bus.req_err), 128'(0));
                chk("quiet_rdata", 128'(bus.req_rdata), 128'(0));
            end
        end
    end

    task automatic drive_port(input int p, input logic re, input logic [3:0] we,
                              input logic [29:0] a, input logic [31:0] d);
        bus.req_re[p]            = re;
        bus.req_we[4*p +: 4]     = we;
        bus.req_addr[30*p +: 30] = a;
        bus.req_wdata[32*p +: 32] = d;
    endtask

    task automatic set_req(input int p, input logic re, input logic [3:0] we,
                           input logic [29:0] a, input logic [31:0] d);
        active[p]  = 1'b1;
        h_re[p]    = re;
        h_we[p]    = we;
        h_addr[p]  = a;
        h_wdata[p] = d;
        drive_port(p, re, we, a, d);
    endtask

    task automatic new_req(input int p);
        int          kind;
        logic [3:0]  we;
        kind = $urandom_range(0, 2);
        we   = 4'($urandom_range(1, 15));
        set_req(p, kind != 1, (kind == 0) ? 4'h0 : we,
                30'($urandom()), $urandom());
    endtask

    function automatic bit any_active();
        bit r;
        r = 1'b0;
        for (int i = 0; i < NP; i++) r |= active[i];
        return r;
    endfunction

    // Called #1 after an edge with the DUT in IDLE; returns one cycle after completion.
    task automatic run_txn(input int lat, input logic [31:0] rd,
                           input bit scramble, input int act_pct);
        exp_t e;
        int   w;
        int   n;
        int   p;
        for (int i = 0; i < NP; i++) begin
            if (!active[i] && act_pct > 0 && $urandom_range(0, 99) < act_pct)
                new_req(i);
            if (active[i]) drive_port(i, h_re[i], h_we[i], h_addr[i], h_wdata[i]);
            else drive_port(i, 1'b0, 4'h0, 30'($urandom()), $urandom());
        end
        w = -1;
        for (int k = 1; k <= NP; k++) begin
            if (w < 0 && active[(rr_last + k) % NP]) w = (rr_last + k) % NP;
        end
        if (w < 0) begin
            @(posedge clk); #1;
            return;
        end
        rr_last = w;
        n       = (lat > TO) ? TO : lat;
        e.port  = w;
        e.cyc   = cyc + n;
        e.err   = lat > TO;
        e.rdata = e.err ? 32'h0 : rd;
        e.re    = h_re[w];
        e.we    = h_we[w];
        e.addr  = h_addr[w];
        e.wdata = h_wdata[w];
        exp_q.push_back(e);
        for (int b = 1; b <= n; b++) begin
            @(posedge clk); #1;
            bus.mem_ready = (b == lat);
            bus.mem_rdata = (b == lat) ? rd : $urandom();
            if (scramble)
                drive_port(w, 1'($urandom()), 4'($urandom()), 30'($urandom()), $urandom());
            p = $urandom_range(0, NP - 1);
            if (b == 1 && p != w && !active[p] && act_pct > 0 &&
                $urandom_range(0, 99) < act_pct)
                new_req(p);
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom();
        chk("idle_mem_re", 128'(bus.mem_re), 128'(0));
        chk("idle_mem_we", 128'(bus.mem_we), 128'(0));
        active[w] = 1'b0;
    endtask

    initial begin
        bus.req_re    = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < NP; i++) active[i] = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_re", 128'(bus.mem_re), 128'(0));
        chk("rst_mem_we", 128'(bus.mem_we), 128'(0));
        chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        chk("rst_mem_wdata", 128'(bus.mem_wdata), 128'(0));
        chk("rst_ready", 128'(bus.req_ready), 128'(0));
        chk("rst_rdata", 128'(bus.req_rdata), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read of byte address 0x1000_0040 from port 0
        set_req(0, 1'b1, 4'h0, 30'h0400_0010, 32'h0);
        run_txn(2, 32'hDEAD_BEEF, 1'b0, 0);

        // Ports 0 and 1 contending with a zero-wait memory
        for (int i = 0; i < 8; i++) begin
            if (!active[0]) new_req(0);
            if (!active[1]) new_req(1);
            run_txn(1, $urandom(), 1'b0, 0);
        end
        for (int i = 0; i < 4 && any_active(); i++) run_txn(1, $urandom(), 1'b0, 0);

        // Port 3 wins, then ports 1 and 3 compete
        new_req(3);
        run_txn(1, $urandom(), 1'b0, 0);
        new_req(1);
        new_req(3);
        run_txn(2, $urandom(), 1'b0, 0);
        run_txn(1, $urandom(), 1'b0, 0);

        // Timeout, late ready on the last allowed cycle, and mid-transaction changes
        new_req(2);
        run_txn(9, $urandom(), 1'b1, 0);
        new_req(2);
        run_txn(5, 32'hCAFE_F00D, 1'b1, 0);
        new_req(1);
        run_txn(6, $urandom(), 1'b0, 0);

        for (int i = 0; i < 150; i++)
            run_txn($urandom_range(1, 7), $urandom(), 1'($urandom()), 40);
        for (int i = 0; i < 20 && any_active(); i++)
            run_txn($urandom_range(1, 3), $urandom(), 1'b0, 0);

        // Reset on the second BUSY cycle aborts the transaction
        new_req(2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_mem_re", 128'(bus.mem_re), 128'(0));
        chk("abort_mem_we", 128'(bus.mem_we), 128'(0));
        active[2] = 1'b0;
        drive_port(2, 1'b0, 4'h0, 30'h0, 32'h0);
        rr_last = NP - 1;
        new_req(0);
        new_req(2);
        run_txn(1, $urandom(), 1'b0, 0);
        run_txn(3, $urandom(), 1'b0, 0);

        for (int i = 0; i < 60; i++)
            run_txn($urandom_range(1, 7), $urandom(), 1'($urandom()), 60);
        for (int i = 0; i < 20 && any_active(); i++)
            run_txn(1, $urandom(), 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_responses", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boa_mem_arbiter.md
Name: boa_mem_arbiter

Overview:
- Shares one memory bus between NPORTS requesters, typically the IF stage program bus and the MEM stage data bus in front of a single-ported RAM.
- Arbitration is round-robin. A grant is held until the memory completes the transaction or a timeout fires.
- The granted request is registered, so the memory side sees stable signals for the whole transaction.

Parameters:
- NPORTS, 2, number of requester ports (2..8).
- TIMEOUT, 0, memory-response timeout in BUSY cycles; 0 disables it.
- TW, 8, width of the timeout counter; requires TIMEOUT < 2**TW.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  synchronous reset, active-high.
- req_re  in  NPORTS  per-port read enable.
- req_we  in  4*NPORTS  per-port byte write enables; port i uses bits [4i+3:4i].
- req_addr  in  30*NPORTS  per-port word address [31:2]; port i uses bits [30i+29:30i].
- req_wdata  in  32*NPORTS  per-port write data.
- req_rdata  out  32*NPORTS  per-port read data.
- req_ready  out  NPORTS  per-port transaction complete, one-cycle pulse.
- req_err  out  NPORTS  per-port timeout error, pulses together with req_ready.
- mem_re  out  1  memory read enable.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  30  memory word address [31:2].
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes the presented transaction.

Behaviour:
- Request definition: port i is requesting when req_re[i]=1 or req_we[i]!=0. A requester holds its signals until it sees req_ready[i].
- Reset values: state=IDLE; mem_re=0; mem_we=0; mem_addr=0; mem_wdata=0; rr_last=NPORTS-1 so port 0 wins first; timeout counter=0. All req_ready, req_err and req_rdata outputs are 0.
- IDLE state:
  - mem_re=0 and mem_we=0.
  - If any port requests, the winner is the first requesting port scanning rr_last+1, rr_last+2, ... modulo NPORTS.
  - At the clock edge: latch the winner's re, we, addr and wdata into the mem_* registers; set grant=winner and rr_last=winner; clear the counter; go to BUSY.
  - With no requests, stay in IDLE.
- BUSY state, memory side: mem_* outputs are driven from the latched registers. Requester inputs are ignored, so a requester dropping its request mid-transaction does not affect the memory side.
- BUSY state, completion: when mem_ready=1, combinationally in the same cycle drive req_ready[grant]=1 and req_rdata[grant]=mem_rdata. At the edge, clear mem_re/mem_we and go to IDLE.
- BUSY state, timeout: when TIMEOUT!=0 and mem_ready=0, the counter increments each cycle. When counter==TIMEOUT-1 and mem_ready=0:
  - drive req_ready[grant]=1, req_err[grant]=1 and req_rdata[grant]=0 that cycle;
  - at the edge, clear mem_re/mem_we and go to IDLE.
  - mem_ready has priority over timeout in the same cycle; in that case err=0.
- Non-granted ports always see ready=0, err=0 and rdata=0. req_rdata[grant] is 0 whenever ready is low.
- Latency and throughput:
  - A request seen at cycle 0 gives mem_* valid at cycle 1; the earliest req_ready is at cycle 1.
  - Back-to-back transactions cost one IDLE cycle each: at most one transaction per 2 cycles.
- Fairness: a continuously requesting port waits at most NPORTS-1 transactions.
- Simultaneous events:
  - Requests arriving during BUSY wait in IDLE arbitration; they are not queued.
  - A write request with req_re=1 is forwarded as both re and we; the memory defines the semantics.
- Reset mid-transaction: rst during BUSY forces IDLE with mem_re=mem_we=0 at the next edge. No req_ready is generated for the aborted transaction.
- State encoding: 2 states, 1 bit.

Test Plan:
- Single read: port 0 reads addr 0x1000_0040 (word 0x0400_0010); memory responds with ready after 2 cycles and rdata=0xDEADBEEF -> mem_re=1 and mem_addr=0x0400_0010 from cycle 1; req_ready[0]=1 and req_rdata[0]=0xDEADBEEF at cycle 2; no ready on port 1.
- Contention: ports 0 and 1 request continuously (NPORTS=2) with zero-wait memory -> grants alternate 0,1,0,1 from reset; each transaction occupies 2 cycles.
- Round-robin with NPORTS=4 and ports 1 and 3 requesting after port 3 last won -> port 1 is granted next, then port 3.
- Timeout: TIMEOUT=5, mem_ready held 0 -> req_ready[grant]=1 with req_err=1 and rdata=0 exactly on the 5th BUSY cycle; mem_re=0 on the next cycle; mem_ready=1 on that same 5th cycle instead gives err=0.
- Mid-transaction change: the requester changes addr/wdata during BUSY -> mem_addr/mem_wdata keep the latched values until completion.
- Reset in BUSY: rst asserted at the 2nd BUSY cycle -> IDLE next cycle, mem_re=mem_we=0, no req_ready pulse, and port 0 wins the next arbitration.
